// File: rtl/shreg_sdc.sv
// ---------------------------------------------------------------------------
// shreg_sdc
//   WIDTH-bit universal shift register with complementary outputs.
//   Supports synchronous set, clear and forced load, hold, single-step
//   left/right shifts, parallel load, and autonomous burst shifts of up to
//   2**CW-1 steps with a busy/done handshake.
//
// Configuration macro:
//   ROTATE_EN  defined   -> shifts rotate; sil/sir are ignored.
//              undefined -> shifts fill from sil (left) / sir (right).
//
// Ports:
//   clk    rising-edge clock
//   nr     asynchronous active-low reset
//   s, c   synchronous set-all / clear-all (both high = forced load of d)
//   mode   00 hold, 01 shift left, 10 shift right, 11 parallel load
//   d      parallel load data
//   sil    serial in for left shift (enters bit 0)
//   sir    serial in for right shift (enters bit WIDTH-1)
//   start  start a burst (IDLE only, mode 01/10)
//   cnt    burst length, sampled with start
//   q, nq  register contents and its registered complement
//   sol    q[WIDTH-1]
//   sor    q[0]
//   busy   high while a burst is in progress
//   done   one-cycle pulse after the last shift of a burst
// ---------------------------------------------------------------------------
module shreg_sdc #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             nr,
  input  logic             s,
  input  logic             c,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             sol,
  output logic             sor,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] nq_q, nq_d;
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;   // 0 = left, 1 = right
  logic             done_q, done_d;

  logic             fill_l, fill_r;
  logic [WIDTH-1:0] shl, shr;

`ifdef ROTATE_EN
  // Serial inputs have no effect when rotating.
  logic unused_serial;
  assign unused_serial = sil ^ sir;
  assign fill_l = q_q[WIDTH-1];
  assign fill_r = q_q[0];
`else
  assign fill_l = sil;
  assign fill_r = sir;
`endif

  assign shl = {q_q[WIDTH-2:0], fill_l};
  assign shr = {fill_r, q_q[WIDTH-1:1]};

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    if (s || c) begin
      // Set/clear/forced load override everything and abort a burst silently.
      if (s && c)  q_d = d;
      else if (s)  q_d = '1;
      else         q_d = '0;
      state_d = IDLE;
      rem_d   = '0;
    end else if (state_q == BURST) begin
      q_d   = dir_q ? shr : shl;
      rem_d = rem_q - CNT_ONE;
      if (rem_q == CNT_ONE) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      unique case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_LEFT:  q_d = shl;
        MODE_RIGHT: q_d = shr;
        MODE_LOAD:  q_d = d;
        default:    q_d = q_q;
      endcase

      if (start && (mode == MODE_LEFT || mode == MODE_RIGHT)) begin
        if (cnt == CNT_ZERO) begin
          // Zero-length burst: no shift, just acknowledge.
          q_d    = q_q;
          done_d = 1'b1;
        end else begin
          // This edge already performs the first shift of the burst.
          dir_d = (mode == MODE_RIGHT);
          rem_d = cnt - CNT_ONE;
          if (cnt == CNT_ONE) done_d  = 1'b1;
          else                state_d = BURST;
        end
      end
    end

    nq_d = ~q_d;
  end

  always_ff @(posedge clk or negedge nr) begin
    if (!nr) begin
      q_q     <= '0;
      nq_q    <= '1;
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      nq_q    <= nq_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign nq   = nq_q;
  assign sol  = q_q[WIDTH-1];
  assign sor  = q_q[0];
  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule

// File: tb/tb_shreg_sdc.sv
module tb_shreg_sdc;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          nr;
  logic          s, c;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic          sil, sir, start;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q, nq;
  logic          sol, sor, busy, done;

  int checks;
  int failures;

  shreg_sdc #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .nr(nr), .s(s), .c(c), .mode(mode), .d(d),
    .sil(sil), .sir(sir), .start(start), .cnt(cnt),
    .q(q), .nq(nq), .sol(sol), .sor(sor), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    s = 0; c = 0; mode = 2'b00; d = '0; sil = 0; sir = 0; start = 0; cnt = '0;
  endtask

  task automatic load(input logic [W-1:0] v);
    mode = 2'b11; d = v;
    tick;
    mode = 2'b00; d = '0;
  endtask

  task automatic test_reset;
    idle_inputs;
    nr = 0;
    #12;
    checks++; if (q !== 8'h00)   begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (nq !== 8'hFF)  begin failures++; $display("FAIL reset_nq got=%h exp=FF", nq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    nr = 1;
    tick;
    $display("test_reset: q=%h nq=%h busy=%b done=%b", q, nq, busy, done);
  endtask

  task automatic test_load_shift;
    load(8'hA5);
    checks++; if (q !== 8'hA5)  begin failures++; $display("FAIL load_q got=%h exp=A5", q); end
    checks++; if (nq !== 8'h5A) begin failures++; $display("FAIL load_nq got=%h exp=5A", nq); end
    mode = 2'b01; sil = 1;
    tick;
    mode = 2'b00; sil = 0;
    checks++; if (q !== 8'h4B) begin failures++; $display("FAIL shl_q got=%h exp=4B", q); end
    checks++; if (sol !== 1'b0 || sor !== 1'b1) begin failures++; $display("FAIL shl_sol_sor got=%b%b exp=01", sol, sor); end
    load(8'hA5);
    mode = 2'b10; sir = 0;
    tick;
    mode = 2'b00;
    checks++; if (q !== 8'h52) begin failures++; $display("FAIL shr_q got=%h exp=52", q); end
    tick;
    checks++; if (q !== 8'h52) begin failures++; $display("FAIL hold_q got=%h exp=52", q); end
    $display("test_load_shift: q=%h nq=%h", q, nq);
  endtask

  task automatic test_burst;
    load(8'h81);
    mode = 2'b10; sir = 0; start = 1; cnt = 4'd3;
    tick;
    // Changes during the burst must be ignored.
    start = 0; cnt = '0; mode = 2'b11; d = 8'hFF;
    checks++; if (busy !== 1'b1 || q !== 8'h40) begin failures++; $display("FAIL burst_e1 got busy=%b q=%h exp busy=1 q=40", busy, q); end
    tick;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h20) begin failures++; $display("FAIL burst_e2 got busy=%b done=%b q=%h exp 1 0 20", busy, done, q); end
    tick;
    mode = 2'b00; d = '0;
    checks++; if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h10) begin failures++; $display("FAIL burst_e3 got busy=%b done=%b q=%h exp 0 1 10", busy, done, q); end
    tick;
    checks++; if (done !== 1'b0 || q !== 8'h10) begin failures++; $display("FAIL burst_after got done=%b q=%h exp 0 10", done, q); end
    $display("test_burst: q=%h busy=%b done=%b", q, busy, done);
  endtask

  task automatic test_abort;
    load(8'h01);
    mode = 2'b01; sil = 0; start = 1; cnt = 4'd5;
    tick;
    start = 0; mode = 2'b00; cnt = '0;
    tick;
    checks++; if (q !== 8'h04 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre got q=%h busy=%b exp 04 1", q, busy); end
    s = 1;
    tick;
    s = 0;
    checks++; if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_set got q=%h busy=%b done=%b exp FF 0 0", q, busy, done); end
    tick;
    checks++; if (q !== 8'hFF || done !== 1'b0) begin failures++; $display("FAIL abort_nodone got q=%h done=%b exp FF 0", q, done); end
    s = 1; c = 1; d = 8'h3C;
    tick;
    checks++; if (q !== 8'h3C || nq !== 8'hC3) begin failures++; $display("FAIL forced_load got q=%h nq=%h exp 3C C3", q, nq); end
    s = 0; d = 8'hFF;
    tick;
    c = 0; d = '0;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL clear got q=%h exp 00", q); end
    $display("test_abort: q=%h busy=%b done=%b", q, busy, done);
  endtask

  task automatic test_short_bursts;
    load(8'h5A);
    mode = 2'b01; sil = 1; start = 1; cnt = 4'd0;
    tick;
    start = 0; mode = 2'b00;
    checks++; if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cnt0 got q=%h done=%b busy=%b exp 5A 1 0", q, done, busy); end
    tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL cnt0_pulse got done=%b exp 0", done); end
    mode = 2'b01; sil = 1; start = 1; cnt = 4'd1;
    tick;
    start = 0; mode = 2'b00; sil = 0;
    checks++; if (q !== 8'hB5 || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cnt1 got q=%h done=%b busy=%b exp B5 1 0", q, done, busy); end
    tick;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'hB5) begin failures++; $display("FAIL cnt1_after got q=%h done=%b busy=%b exp B5 0 0", q, done, busy); end
    $display("test_short_bursts: q=%h", q);
  endtask

  task automatic test_back_to_back;
    load(8'h01);
    mode = 2'b01; sil = 0; start = 1; cnt = 4'd2;
    tick;
    checks++; if (q !== 8'h02 || busy !== 1'b1) begin failures++; $display("FAIL b2b_e1 got q=%h busy=%b exp 02 1", q, busy); end
    tick;  // start still high during BURST: ignored
    checks++; if (q !== 8'h04 || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_e2 got q=%h done=%b busy=%b exp 04 1 0", q, done, busy); end
    tick;  // start coincides with done: new burst begins
    start = 0; mode = 2'b00;
    checks++; if (q !== 8'h08 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_new got q=%h busy=%b done=%b exp 08 1 0", q, busy, done); end
    tick;
    checks++; if (q !== 8'h10 || done !== 1'b1) begin failures++; $display("FAIL b2b_end got q=%h done=%b exp 10 1", q, done); end
    tick;
    $display("test_back_to_back: q=%h", q);
  endtask

  task automatic test_serial_or_rotate;
    load(8'h81);
    mode = 2'b01; sil = 0;
    tick;
    mode = 2'b00;
`ifdef ROTATE_EN
    checks++; if (q !== 8'h03 || nq !== 8'hFC) begin failures++; $display("FAIL rot_left got q=%h nq=%h exp 03 FC", q, nq); end
`else
    checks++; if (q !== 8'h02 || nq !== 8'hFD) begin failures++; $display("FAIL fill_left got q=%h nq=%h exp 02 FD", q, nq); end
`endif
    load(8'h81);
    mode = 2'b10; sir = 1;
    tick;
    mode = 2'b00; sir = 0;
`ifdef ROTATE_EN
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL rot_right got q=%h exp C0", q); end
`else
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL fill_right got q=%h exp C0", q); end
    // serial inputs sampled at every burst edge
    load(8'h00);
    mode = 2'b01; start = 1; cnt = 4'd4; sil = 1;
    tick;
    start = 0; mode = 2'b00; sil = 0;
    tick;
    sil = 1;
    tick;
    tick;
    sil = 0;
    checks++; if (q !== 8'h0B || done !== 1'b1) begin failures++; $display("FAIL burst_sil got q=%h done=%b exp 0B 1", q, done); end
`endif
    // complement tracks across a short sequence
    load(8'h6D);
    for (int i = 0; i < 4; i++) begin
      mode = (i % 2 == 0) ? 2'b01 : 2'b10;
      sil = 1; sir = 0;
      tick;
      checks++; if (nq !== ~q) begin failures++; $display("FAIL nq_track step=%0d got nq=%h q=%h", i, nq, q); end
    end
    idle_inputs;
    $display("test_serial_or_rotate: q=%h nq=%h", q, nq);
  endtask

  task automatic test_reset_mid_burst;
    load(8'hFF);
    mode = 2'b10; sir = 0; start = 1; cnt = 4'd7;
    tick;
    start = 0; mode = 2'b00;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmb_busy got=%b exp=1", busy); end
    #2;
    nr = 0;
    #1;
    checks++; if (q !== 8'h00 || nq !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmb_async got q=%h nq=%h busy=%b done=%b exp 00 FF 0 0", q, nq, busy, done); end
    #3;
    nr = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin failures++; $display("FAIL rmb_after cyc=%0d got q=%h busy=%b done=%b exp 00 0 0", i, q, busy, done); end
    end
    $display("test_reset_mid_burst: q=%h busy=%b done=%b", q, busy, done);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_load_shift;
    test_burst;
    test_abort;
    test_short_bursts;
    test_back_to_back;
    test_serial_or_rotate;
    test_reset_mid_burst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
